// File: rtl/unidade_busca_pkg.sv
// nRISC shared definitions: opcode encodings, instruction field layout and
// the fetch/sequencing state type.
package nrisc_pkg;

  localparam logic [2:0] OP_HALT    = 3'b000;
  localparam logic [2:0] OP_ADD_SUB = 3'b001;
  localparam logic [2:0] OP_LW_SW   = 3'b010;
  localparam logic [2:0] OP_J       = 3'b011;
  localparam logic [2:0] OP_LI      = 3'b100;
  localparam logic [2:0] OP_SLT_NOT = 3'b101;
  localparam logic [2:0] OP_BEQ     = 3'b110;

  // Opcode sits in the top bits of the instruction, funct in bit 0.
  localparam int unsigned LARGURA_OPCODE = 3;
  localparam int unsigned POS_FUNCT      = 0;
  localparam int unsigned LARGURA_CONT   = 16;

  typedef enum logic [1:0] {
    BUSCA,
    EXEC,
    PARADO
  } estado_busca_t;

endpackage

// File: rtl/unidade_busca_if.sv
// Instruction-memory read channel: request/address out, data/valid back.
interface unidade_busca_if #(
  parameter int unsigned LARGURA_PC    = 8,
  parameter int unsigned LARGURA_INSTR = 8
);
  logic                     Mem_Req;
  logic [LARGURA_PC-1:0]    Mem_Addr;
  logic [LARGURA_INSTR-1:0] Mem_Dado;
  logic                     Mem_Valid;

  modport master (output Mem_Req, Mem_Addr, input Mem_Dado, Mem_Valid);
  modport slave  (input Mem_Req, Mem_Addr, output Mem_Dado, Mem_Valid);
endinterface

// File: rtl/unidade_busca_calc_prox_pc.sv
// Next-PC selection: halt holds, taken jump/branch adds the offset to PC+1,
// otherwise sequential. All arithmetic wraps modulo 2^LARGURA_PC.
module calc_prox_pc #(
  parameter int unsigned LARGURA_PC = 8
) (
  input  logic [LARGURA_PC-1:0] pc,
  input  logic [LARGURA_PC-1:0] imm_desvio,
  input  logic                  branch,
  input  logic                  jump,
  input  logic                  halt,
  input  logic                  zero,
  output logic [LARGURA_PC-1:0] pc_prox
);
  localparam logic [LARGURA_PC-1:0] UM = LARGURA_PC'(1);

  always_comb begin
    pc_prox = pc + UM;
    if (halt)
      pc_prox = pc;
    else if (jump || (branch && zero))
      pc_prox = pc + UM + imm_desvio;
  end
endmodule

// File: rtl/unidade_busca.sv
// nRISC instruction fetch/sequencing unit: fetches over the memory handshake,
// holds the instruction during execution and retires it into the next PC.
module unidade_busca
  import nrisc_pkg::*;
#(
  parameter int unsigned             LARGURA_PC    = 8,
  parameter int unsigned             LARGURA_INSTR = 8,
  parameter logic [LARGURA_PC-1:0]   PC_RESET      = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  unidade_busca_if.master           mem,
  output logic [LARGURA_INSTR-1:0]  Instr,
  output logic [2:0]                Opcode,
  output logic                      Funct,
  output logic                      Instr_Valida,
  input  logic                      Exec_Pronto,
  input  logic                      Branch,
  input  logic                      Jump,
  input  logic                      Halt,
  input  logic                      Zero,
  input  logic [LARGURA_PC-1:0]     Imm_Desvio,
  output logic [LARGURA_PC-1:0]     PC,
  output logic                      Parado,
  output logic [LARGURA_CONT-1:0]   Contador_Instr
);

  estado_busca_t            estado, estado_prox;
  logic [LARGURA_PC-1:0]    pc_prox, pc_calc;
  logic [LARGURA_INSTR-1:0] instr_prox;
  logic [LARGURA_CONT-1:0]  cont_prox;

  calc_prox_pc #(.LARGURA_PC(LARGURA_PC)) u_calc_prox_pc (
    .pc         (PC),
    .imm_desvio (Imm_Desvio),
    .branch     (Branch),
    .jump       (Jump),
    .halt       (Halt),
    .zero       (Zero),
    .pc_prox    (pc_calc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      estado         <= BUSCA;
      PC             <= PC_RESET;
      Instr          <= '0;
      Contador_Instr <= '0;
    end else begin
      estado         <= estado_prox;
      PC             <= pc_prox;
      Instr          <= instr_prox;
      Contador_Instr <= cont_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    pc_prox     = PC;
    instr_prox  = Instr;
    cont_prox   = Contador_Instr;
    case (estado)
      BUSCA: begin
        if (mem.Mem_Valid) begin
          instr_prox  = mem.Mem_Dado;
          estado_prox = EXEC;
        end
      end
      EXEC: begin
        if (Exec_Pronto) begin
          if (Contador_Instr != '1)
            cont_prox = Contador_Instr + LARGURA_CONT'(1);
          pc_prox     = pc_calc;
          estado_prox = Halt ? PARADO : BUSCA;
        end
      end
      PARADO: estado_prox = PARADO;
      default: estado_prox = BUSCA;
    endcase
  end

  // Request is gated by rst so it reads 0 while reset is held, even though
  // the state register already sits in BUSCA.
  assign mem.Mem_Req   = (estado == BUSCA) && !rst;
  assign mem.Mem_Addr  = PC;
  assign Instr_Valida  = (estado == EXEC);
  assign Parado        = (estado == PARADO);
  assign Opcode        = Instr[LARGURA_INSTR-1 -: LARGURA_OPCODE];
  assign Funct         = Instr[POS_FUNCT];

endmodule

// File: tb/tb_unidade_busca.sv
// Randomized bench for unidade_busca against a behavioural PC/counter model.
module tb_unidade_busca;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  Instr;
  logic [2:0]  Opcode;
  logic        Funct;
  logic        Instr_Valida;
  logic        Exec_Pronto;
  logic        Branch, Jump, Halt, Zero;
  logic [7:0]  Imm_Desvio;
  logic [7:0]  PC;
  logic        Parado;
  logic [15:0] Contador_Instr;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  int unsigned mpc;
  int unsigned mcnt;
  logic [7:0]  minstr;
  logic        mhalt;

  unidade_busca_if #(.LARGURA_PC(8), .LARGURA_INSTR(8)) mem_if ();

  unidade_busca #(.LARGURA_PC(8), .LARGURA_INSTR(8), .PC_RESET(8'h00)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem            (mem_if),
    .Instr          (Instr),
    .Opcode         (Opcode),
    .Funct          (Funct),
    .Instr_Valida   (Instr_Valida),
    .Exec_Pronto    (Exec_Pronto),
    .Branch         (Branch),
    .Jump           (Jump),
    .Halt           (Halt),
    .Zero           (Zero),
    .Imm_Desvio     (Imm_Desvio),
    .PC             (PC),
    .Parado         (Parado),
    .Contador_Instr (Contador_Instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mpc = 0; mcnt = 0; minstr = 8'h00; mhalt = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_if.Mem_Valid = 1'b0;
    mem_if.Mem_Dado  = 8'($urandom);
    Exec_Pronto = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    model_reset();
    chk("rst_req",    mem_if.Mem_Req, 0);
    chk("rst_pc",     PC, mpc);
    chk("rst_instr",  Instr, 0);
    chk("rst_valida", Instr_Valida, 0);
    chk("rst_parado", Parado, 0);
    chk("rst_cont",   Contador_Instr, 0);
    rst = 1'b0;
  endtask

  task automatic run_instr(input int unsigned waits, input int unsigned execw,
                           input logic [7:0] word, input logic b, input logic j,
                           input logic h, input logic z, input logic [7:0] imm);
    for (int unsigned w = 0; w < waits; w++) begin
      mem_if.Mem_Valid = 1'b0;
      mem_if.Mem_Dado  = 8'($urandom);
      Exec_Pronto      = 1'($urandom);
      #1;
      chk("busca_req",  mem_if.Mem_Req, 1);
      chk("busca_addr", mem_if.Mem_Addr, mpc);
      chk("instr_hold", Instr, minstr);
      @(negedge clk);
    end
    mem_if.Mem_Valid = 1'b1;
    mem_if.Mem_Dado  = word;
    Exec_Pronto      = 1'($urandom);
    #1;
    chk("accept_req",  mem_if.Mem_Req, 1);
    chk("accept_addr", mem_if.Mem_Addr, mpc);
    @(negedge clk);
    minstr = word;
    for (int unsigned e = 0; e < execw; e++) begin
      mem_if.Mem_Valid = 1'($urandom);
      mem_if.Mem_Dado  = 8'($urandom);
      Exec_Pronto = 1'b0;
      {Branch, Jump, Halt, Zero} = 4'($urandom);
      Imm_Desvio = 8'($urandom);
      #1;
      chk("exec_valida", Instr_Valida, 1);
      chk("exec_instr",  Instr, minstr);
      chk("exec_req",    mem_if.Mem_Req, 0);
      chk("exec_pc",     PC, mpc);
      @(negedge clk);
    end
    mem_if.Mem_Valid = 1'($urandom);
    mem_if.Mem_Dado  = 8'($urandom);
    Exec_Pronto = 1'b1;
    Branch = b; Jump = j; Halt = h; Zero = z; Imm_Desvio = imm;
    #1;
    chk("ret_valida", Instr_Valida, 1);
    chk("ret_opcode", Opcode, minstr[7:5]);
    chk("ret_funct",  Funct, minstr[0]);
    chk("ret_instr",  Instr, minstr);
    @(negedge clk);
    Exec_Pronto = 1'b0;
    mem_if.Mem_Valid = 1'b0;
    if (mcnt < 65535) mcnt = mcnt + 1;
    if (h)                 mhalt = 1'b1;
    else if (j || (b && z)) mpc = (mpc + 1 + imm) % 256;
    else                   mpc = (mpc + 1) % 256;
    #1;
    chk("post_pc",     PC, mpc);
    chk("post_cont",   Contador_Instr, mcnt);
    chk("post_parado", Parado, mhalt);
    chk("post_valida", Instr_Valida, 0);
    chk("post_req",    mem_if.Mem_Req, !mhalt);
  endtask

  task automatic halt_hold(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      mem_if.Mem_Valid = 1'($urandom);
      mem_if.Mem_Dado  = 8'($urandom);
      Exec_Pronto      = 1'($urandom);
      {Branch, Jump, Halt, Zero} = 4'($urandom);
      @(negedge clk);
      #1;
      chk("halt_parado", Parado, 1);
      chk("halt_req",    mem_if.Mem_Req, 0);
      chk("halt_pc",     PC, mpc);
      chk("halt_instr",  Instr, minstr);
    end
    Exec_Pronto = 1'b0;
    mem_if.Mem_Valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    Exec_Pronto = 1'b0;
    {Branch, Jump, Halt, Zero} = 4'b0;
    Imm_Desvio = 8'h00;
    mem_if.Mem_Valid = 1'b0;
    mem_if.Mem_Dado  = 8'h00;
    model_reset();

    do_reset();
    run_instr(0, 0, 8'h20, 0, 0, 0, 0, 8'h00);
    chk("first_pc", PC, 1);
    chk("first_cont", Contador_Instr, 1);
    run_instr(3, 1, 8'h41, 0, 0, 0, 0, 8'h00);
    run_instr(0, 0, 8'hA0, 0, 0, 0, 1, 8'h33);
    run_instr(1, 0, 8'h80, 0, 0, 0, 0, 8'h00);
    run_instr(0, 2, 8'hA1, 0, 0, 0, 0, 8'h00);
    chk("at_5", PC, 5);
    run_instr(0, 0, 8'h60, 1, 1, 0, 0, 8'hFD);
    chk("jump_back", PC, 3);
    run_instr(0, 0, 8'h60, 0, 1, 0, 0, 8'hFE);
    run_instr(0, 0, 8'hC0, 1, 0, 0, 0, 8'h04);
    chk("branch_nt", PC, 3);
    run_instr(0, 0, 8'h60, 0, 1, 0, 0, 8'hFE);
    run_instr(2, 0, 8'hC0, 1, 0, 0, 1, 8'h04);
    chk("branch_t", PC, 7);
    run_instr(0, 0, 8'h21, 0, 0, 0, 1, 8'h10);
    run_instr(0, 0, 8'h20, 0, 0, 0, 0, 8'h00);
    run_instr(0, 1, 8'h00, 1, 1, 1, 1, 8'h05);
    chk("halt_pc9", PC, 9);
    halt_hold(20);
    do_reset();
    #1;
    chk("rst_after_halt_req", mem_if.Mem_Req, 1);

    run_instr(0, 0, 8'h60, 0, 1, 0, 0, 8'hFD);
    run_instr(0, 0, 8'h20, 0, 0, 0, 0, 8'h00);
    chk("at_ff", PC, 8'hFF);
    run_instr(1, 0, 8'h20, 0, 0, 0, 0, 8'h00);
    chk("wrap", PC, 0);

    for (int i = 0; i < 150; i++) begin
      run_instr($urandom_range(0, 3), $urandom_range(0, 2), 8'($urandom),
                1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0),
                1'($urandom), 8'($urandom));
      if (mhalt) begin
        halt_hold(3);
        do_reset();
      end
    end

    // Abort a fetch in its second wait cycle
    run_instr(0, 0, 8'h60, 0, 1, 0, 0, 8'h41);
    mem_if.Mem_Valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    chk("abort_req",   mem_if.Mem_Req, 0);
    chk("abort_pc",    PC, 0);
    chk("abort_cont",  Contador_Instr, 0);
    chk("abort_instr", Instr, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("refetch_req",  mem_if.Mem_Req, 1);
    chk("refetch_addr", mem_if.Mem_Addr, 0);
    run_instr(0, 0, 8'h20, 0, 0, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
